// File: rtl/pe_sched_pkg.sv
// Shared types and address helpers for the PE cluster schedulers.
package pe_sched_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAITV, FINISH} sched_state_e;

    // 32-bit words per input pixel (four int8 channels per word)
    function automatic int unsigned calc_cw(input int unsigned ifm_c);
        return ifm_c / 4;
    endfunction

    function automatic int unsigned calc_win(input int unsigned kernel_w, input int unsigned ifm_c);
        return kernel_w * kernel_w * calc_cw(ifm_c);
    endfunction

    function automatic int unsigned calc_ng(input int unsigned ofm_c, input int unsigned num_pe);
        return ofm_c / num_pe;
    endfunction

    function automatic logic [63:0] calc_ifm_addr(
        input logic [31:0] oy,
        input logic [31:0] ox,
        input logic [31:0] ky,
        input logic [31:0] kx,
        input logic [31:0] cw,
        input int unsigned stride,
        input int unsigned ifm_w,
        input int unsigned cw_n
    );
        logic [63:0] row;
        logic [63:0] col;
        row = 64'(oy) * 64'(stride) + 64'(ky);
        col = 64'(ox) * 64'(stride) + 64'(kx);
        return (row * 64'(ifm_w) + col) * 64'(cw_n) + 64'(cw);
    endfunction

endpackage

// File: rtl/pe_sched_win_cnt.sv
// Nested ky/kx/cw window counter; wraps to zero after the last position.
module pe_sched_win_cnt #(
    parameter int unsigned KERNEL_W = 3,
    parameter int unsigned CW       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [31:0] ky,
    output logic [31:0] kx,
    output logic [31:0] cw,
    output logic        first,
    output logic        last
);

    logic [31:0] ky_q, kx_q, cw_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ky_q <= '0;
            kx_q <= '0;
            cw_q <= '0;
        end else if (step) begin
            if (cw_q == CW - 1) begin
                cw_q <= '0;
                if (kx_q == KERNEL_W - 1) begin
                    kx_q <= '0;
                    ky_q <= (ky_q == KERNEL_W - 1) ? '0 : ky_q + 32'd1;
                end else begin
                    kx_q <= kx_q + 32'd1;
                end
            end else begin
                cw_q <= cw_q + 32'd1;
            end
        end
    end

    assign ky    = ky_q;
    assign kx    = kx_q;
    assign cw    = cw_q;
    assign first = (ky_q == '0) && (kx_q == '0) && (cw_q == '0);
    assign last  = (ky_q == KERNEL_W - 1) && (kx_q == KERNEL_W - 1) && (cw_q == CW - 1);

endmodule

// File: rtl/pe_cluster_sched.sv
// Window-by-window IFM/weight address sequencer for the PE convolution cluster.
// Defining PE_CLUSTER_SCHED_PERF_EN adds the cyc_cnt/stall_cnt performance counters.
module pe_cluster_sched
    import pe_sched_pkg::*;
#(
    parameter int unsigned KERNEL_W = 3,
    parameter int unsigned IFM_W    = 58,
    parameter int unsigned IFM_C    = 32,
    parameter int unsigned OFM_W    = 56,
    parameter int unsigned OFM_C    = 128,
    parameter int unsigned STRIDE   = 1,
    parameter int unsigned NUM_PE   = 16,
    parameter int unsigned BRAM_LAT = 1,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_PE-1:0] valid,
    output logic [ADDR_W-1:0] addr_ifm,
    output logic [19:0]       addr_w,
    output logic [NUM_PE-1:0] pe_reset,
    output logic [NUM_PE-1:0] pe_finish,
    output logic              ofm_we,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic              busy,
    output logic              done
`ifdef PE_CLUSTER_SCHED_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned CW  = calc_cw(IFM_C);
    localparam int unsigned WIN = calc_win(KERNEL_W, IFM_C);
    localparam int unsigned NG  = calc_ng(OFM_C, NUM_PE);

    sched_state_e state_q, state_d;
    logic [31:0]  g_q, oy_q, ox_q;
    logic [31:0]  ky, kx, cw;
    logic         win_first, win_last, win_step, pix_step, pix_last;
    logic [1:0]   drain_q;
    logic [BRAM_LAT-1:0] rst_sr_q, fin_sr_q;

    pe_sched_win_cnt #(
        .KERNEL_W(KERNEL_W),
        .CW      (CW)
    ) u_win_cnt (
        .clk  (clk),
        .reset(reset),
        .step (win_step),
        .ky   (ky),
        .kx   (kx),
        .cw   (cw),
        .first(win_first),
        .last (win_last)
    );

    assign pix_last = (g_q == NG - 1) && (oy_q == OFM_W - 1) && (ox_q == OFM_W - 1);

    always_comb begin
        state_d  = state_q;
        win_step = 1'b0;
        pix_step = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = ISSUE;
            ISSUE: begin
                // window counter parks on its last position so addresses hold through DRAIN
                if (win_last) state_d = DRAIN;
                else          win_step = 1'b1;
            end
            DRAIN:  if (drain_q == 2'(BRAM_LAT - 1)) state_d = WAITV;
            WAITV: begin
                if (&valid) begin
                    win_step = 1'b1;
                    pix_step = 1'b1;
                    state_d  = pix_last ? FINISH : ISSUE;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
        end
    end

    // ox fastest, then oy, then filter group
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q  <= '0;
            oy_q <= '0;
            ox_q <= '0;
        end else if (pix_step) begin
            if (ox_q == OFM_W - 1) begin
                ox_q <= '0;
                if (oy_q == OFM_W - 1) begin
                    oy_q <= '0;
                    g_q  <= (g_q == NG - 1) ? '0 : g_q + 32'd1;
                end else begin
                    oy_q <= oy_q + 32'd1;
                end
            end else begin
                ox_q <= ox_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sr_q <= '0;
            fin_sr_q <= '0;
        end else begin
            rst_sr_q[0] <= (state_q == ISSUE) && win_first;
            fin_sr_q[0] <= (state_q == ISSUE) && win_last;
            for (int i = 1; i < BRAM_LAT; i++) begin
                rst_sr_q[i] <= rst_sr_q[i-1];
                fin_sr_q[i] <= fin_sr_q[i-1];
            end
        end
    end

    assign addr_ifm  = ADDR_W'(calc_ifm_addr(oy_q, ox_q, ky, kx, cw, STRIDE, IFM_W, CW));
    assign addr_w    = 20'(64'(g_q) * 64'(WIN)
                           + (64'(ky) * 64'(KERNEL_W) + 64'(kx)) * 64'(CW) + 64'(cw));
    assign ofm_addr  = ADDR_W'((64'(oy_q) * 64'(OFM_W) + 64'(ox_q)) * 64'(NG) + 64'(g_q));
    assign ofm_we    = (state_q == WAITV) && (&valid);
    assign pe_reset  = {NUM_PE{rst_sr_q[BRAM_LAT-1]}};
    assign pe_finish = {NUM_PE{fin_sr_q[BRAM_LAT-1]}};
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == WAITV);
    assign done      = (state_q == FINISH);

`ifdef PE_CLUSTER_SCHED_PERF_EN
    logic [31:0] cyc_q, stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (busy && (cyc_q != '1))                  cyc_q   <= cyc_q + 32'd1;
            if ((state_q == WAITV) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_cluster_sched.sv
// Scoreboard bench for pe_cluster_sched over four parameter sets (incl. defaults).
module tb_pe_cluster_sched;

    typedef struct packed {
        logic [31:0] ifm;
        logic [19:0] w;
        logic        first;
        logic        last;
    } op_t;

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fin_cnt = 0;

    always #5 clk = ~clk;

    task automatic check(input int inst, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [%0d] %s: got %0h expected %0h", inst, name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_inst
        localparam int unsigned K   = (gi == 2) ? 1 : 3;
        localparam int unsigned IW  = (gi == 0) ? 6 : (gi == 1) ? 9 : (gi == 2) ? 4 : 58;
        localparam int unsigned IC  = (gi == 0) ? 8 : (gi == 3) ? 32 : 4;
        localparam int unsigned OW  = (gi == 3) ? 56 : 4;
        localparam int unsigned OC  = (gi == 1) ? 16 : (gi == 3) ? 128 : 32;
        localparam int unsigned S   = (gi == 1) ? 2 : 1;
        localparam int unsigned L   = (gi == 0 || gi == 3) ? 1 : 2;
        localparam int unsigned CWN = IC / 4;
        localparam int unsigned WN  = K * K * CWN;
        localparam int unsigned NGN = OC / 16;
        localparam int unsigned TOT = NGN * OW * OW;

        logic        rst = 1'b1;
        logic        start = 1'b0;
        logic        partial = 1'b0;
        logic [15:0] vld;
        logic [31:0] addr_ifm, ofm_addr;
        logic [19:0] addr_w;
        logic [15:0] pe_reset, pe_finish;
        logic        ofm_we, busy, done;
`ifdef PE_CLUSTER_SCHED_PERF_EN
        logic [31:0] cyc_cnt, stall_cnt;
`endif

        op_t         op_q[$];
        logic [31:0] ofm_q[$];
        logic [31:0] h_ifm[4];
        logic [19:0] h_w[4];
        int          ofm_seen = 0, win_started = 0, done_seen = 0;
        int          cyc = 0, last_ofm_cyc = 0;
        bit          in_win = 1'b0, prev_busy = 1'b0;

        assign vld = partial ? 16'h7FFF : 16'hFFFF;

        pe_cluster_sched #(
            .KERNEL_W(K), .IFM_W(IW), .IFM_C(IC), .OFM_W(OW), .OFM_C(OC),
            .STRIDE(S), .NUM_PE(16), .BRAM_LAT(L), .ADDR_W(32)
        ) dut (
            .clk      (clk),
            .reset    (rst),
            .start    (start),
            .valid    (vld),
            .addr_ifm (addr_ifm),
            .addr_w   (addr_w),
            .pe_reset (pe_reset),
            .pe_finish(pe_finish),
            .ofm_we   (ofm_we),
            .ofm_addr (ofm_addr),
            .busy     (busy),
            .done     (done)
`ifdef PE_CLUSTER_SCHED_PERF_EN
            ,
            .cyc_cnt  (cyc_cnt),
            .stall_cnt(stall_cnt)
`endif
        );

        // Expected operand stream and OFM addresses for the first nwin windows.
        task automatic push_windows(input int unsigned nwin);
            int unsigned n = 0;
            for (int unsigned g = 0; g < NGN; g++)
                for (int unsigned oy = 0; oy < OW; oy++)
                    for (int unsigned ox = 0; ox < OW; ox++) begin
                        if (n < nwin) begin
                            for (int unsigned ky = 0; ky < K; ky++)
                                for (int unsigned kx = 0; kx < K; kx++)
                                    for (int unsigned c = 0; c < CWN; c++) begin
                                        op_t e;
                                        int unsigned idx;
                                        idx     = (ky * K + kx) * CWN + c;
                                        e.ifm   = 32'(((oy * S + ky) * IW + ox * S + kx) * CWN + c);
                                        e.w     = 20'(g * WN + idx);
                                        e.first = (idx == 0);
                                        e.last  = (idx == WN - 1);
                                        op_q.push_back(e);
                                    end
                            ofm_q.push_back(32'((oy * OW + ox) * NGN + g));
                            n++;
                        end
                    end
        endtask

        task automatic check_zero(input string tag);
            check(gi, {tag, ".addr_ifm"}, 64'(addr_ifm), 64'd0);
            check(gi, {tag, ".addr_w"}, 64'(addr_w), 64'd0);
            check(gi, {tag, ".pe_reset"}, 64'(pe_reset), 64'd0);
            check(gi, {tag, ".pe_finish"}, 64'(pe_finish), 64'd0);
            check(gi, {tag, ".ofm_we"}, 64'(ofm_we), 64'd0);
            check(gi, {tag, ".ofm_addr"}, 64'(ofm_addr), 64'd0);
            check(gi, {tag, ".busy"}, 64'(busy), 64'd0);
            check(gi, {tag, ".done"}, 64'(done), 64'd0);
`ifdef PE_CLUSTER_SCHED_PERF_EN
            check(gi, {tag, ".cyc_cnt"}, 64'(cyc_cnt), 64'd0);
`endif
        endtask

        task automatic wait_ofm(input int n);
            for (int i = 0; i < 2000 && ofm_seen < n; i++) tick(1);
            check(gi, "wait_ofm", 64'(ofm_seen >= n), 64'd1);
        endtask

        task automatic pulse_start();
            start = 1'b1;
            tick(1);
            start = 1'b0;
        endtask

        always @(negedge clk) begin
            cyc++;
            if (rst) begin
                in_win = 1'b0;
                win_started = 0;
                ofm_seen = 0;
                done_seen = 0;
                for (int i = 0; i < 4; i++) begin
                    h_ifm[i] = '0;
                    h_w[i] = '0;
                end
            end else begin
                for (int i = 3; i > 0; i--) begin
                    h_ifm[i] = h_ifm[i-1];
                    h_w[i] = h_w[i-1];
                end
                h_ifm[0] = addr_ifm;
                h_w[0] = addr_w;
                if (!in_win && pe_reset != '0) begin
                    check(gi, "win_order", 64'(ofm_seen), 64'(win_started));
                    win_started++;
                    in_win = 1'b1;
                end else if (!in_win && pe_finish != '0) begin
                    check(gi, "stray_finish", 64'(pe_finish), 64'd0);
                end
                if (in_win) begin
                    if (op_q.size() == 0) begin
                        check(gi, "op_extra", 64'd1, 64'd0);
                        in_win = 1'b0;
                    end else begin
                        op_t e;
                        e = op_q.pop_front();
                        check(gi, "op_ifm", 64'(h_ifm[L]), 64'(e.ifm));
                        check(gi, "op_w", 64'(h_w[L]), 64'(e.w));
                        check(gi, "pe_reset", 64'(pe_reset), e.first ? 64'hFFFF : 64'd0);
                        check(gi, "pe_finish", 64'(pe_finish), e.last ? 64'hFFFF : 64'd0);
                        if (e.last) in_win = 1'b0;
                    end
                end
                if (ofm_we) begin
                    check(gi, "ofm_valid_full", 64'(vld), 64'hFFFF);
                    if (ofm_q.size() == 0) check(gi, "ofm_extra", 64'd1, 64'd0);
                    else check(gi, "ofm_addr", 64'(ofm_addr), 64'(ofm_q.pop_front()));
                    ofm_seen++;
                    last_ofm_cyc = cyc;
                end
                if (done) begin
                    check(gi, "done_count", 64'(ofm_seen), 64'(TOT));
                    check(gi, "done_gap", 64'(cyc - last_ofm_cyc), 64'd1);
                    check(gi, "done_busy", 64'(busy), 64'd0);
                    check(gi, "busy_before_done", 64'(prev_busy), 64'd1);
                    done_seen++;
                end
            end
            prev_busy = busy;
        end

        initial begin
            tick(3);
            rst = 1'b0;
            tick(1);
            check_zero("reset_state");

            // Layer A: partial valid stall, start while busy, async reset mid-ISSUE.
            push_windows(4);
            pulse_start();
            check(gi, "busy_after_start", 64'(busy), 64'd1);
            wait_ofm(1);
            partial = 1'b1;
            tick(WN + L + 20);
            check(gi, "partial_hold", 64'(ofm_seen), 64'd1);
            check(gi, "stall_busy", 64'(busy), 64'd1);
            pulse_start();
            partial = 1'b0;
            tick(2);
            check(gi, "release_one", 64'(ofm_seen), 64'd2);
            wait_ofm(3);
            #2 rst = 1'b1;
            #1 check_zero("async_reset");
            op_q.delete();
            ofm_q.delete();
            tick(2);
            rst = 1'b0;
            tick(1);

            // Layer B: complete layer from the restart (small configurations only).
            if (TOT <= 1000) begin
                push_windows(TOT);
                pulse_start();
                for (int i = 0; i < 5000 && done_seen < 1; i++) tick(1);
                check(gi, "layer_done", 64'(done_seen), 64'd1);
                tick(3);
                check(gi, "idle_busy", 64'(busy), 64'd0);
                check(gi, "idle_done", 64'(done), 64'd0);
                check(gi, "op_q_drained", 64'(op_q.size()), 64'd0);
                check(gi, "ofm_q_drained", 64'(ofm_q.size()), 64'd0);
`ifdef PE_CLUSTER_SCHED_PERF_EN
                check(gi, "cyc_cnt", 64'(cyc_cnt), 64'(TOT * (WN + L + 1)));
                check(gi, "stall_cnt", 64'(stall_cnt), 64'(TOT));
`endif
            end
            fin_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && fin_cnt < 4; i++) @(posedge clk);
        check(9, "all_finished", 64'(fin_cnt), 64'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
